// File: rtl/seqdet_pkg.sv
// -----------------------------------------------------------------------------
// seqdet_pkg
// Shared definitions for the pattern hit counter block:
//   NUM_PAT   - number of 3-bit patterns tracked (y000..y111)
//   CNT_W_DEF - default width of each per-pattern hit counter
//   state_t   - dump FSM state encoding
// -----------------------------------------------------------------------------
package seqdet_pkg;

    localparam int NUM_PAT   = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : seqdet_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with a read-and-clear style load.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset (already deassert-synchronised)
//   inc       - add 1 this cycle (ignored once saturated)
//   load_zero - load 0 this cycle, or 1 if inc is also high
//   value     - current count
//   sat       - value is at its maximum (all ones)
// -----------------------------------------------------------------------------
module sat_counter
    import seqdet_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             load_zero,
    output logic [CNT_W-1:0] value,
    output logic             sat
);

    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    // A hit landing in the same cycle the value is read out must not be lost,
    // so the load starts the new epoch at 1 instead of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load_zero) begin
            value <= inc ? CNT_W'(1) : '0;
        end else if (inc && !sat) begin
            value <= value + CNT_W'(1);
        end
    end

    assign sat = (value == MAX_VAL);

endmodule : sat_counter

// File: rtl/pattern_hit_counter.sv
// -----------------------------------------------------------------------------
// pattern_hit_counter
// Counts hits for each of the eight 3-bit patterns reported by the upstream
// sequence detector and streams all eight counters out on request.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset (deassertion synchronised)
//   en         - count enable
//   y000..y111 - per-pattern detect flags
//   clr        - synchronous clear of counters and dump FSM (highest priority)
//   dump_start - start streaming the eight counters (honoured in IDLE only)
//   out_valid  - out_idx/out_count hold a valid entry
//   out_ready  - consumer accepts the entry
//   out_idx    - pattern index of the current entry
//   out_count  - live value of counter[out_idx]
//   busy       - FSM is not in IDLE
//   any_sat    - at least one counter is saturated
//   state_dbg  - current dump FSM state
//
// Output handshake: an entry moves on a cycle where out_valid and out_ready
// are both high. While out_valid is high and out_ready is low, out_valid and
// out_idx hold; out_count stays tied to the selected counter and so may rise
// if that pattern keeps hitting. The transferred counter is cleared by the
// same edge (read-and-clear).
// -----------------------------------------------------------------------------
module pattern_hit_counter
    import seqdet_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             y000,
    input  logic             y001,
    input  logic             y010,
    input  logic             y011,
    input  logic             y100,
    input  logic             y101,
    input  logic             y110,
    input  logic             y111,
    input  logic             clr,
    input  logic             dump_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_idx,
    output logic [CNT_W-1:0] out_count,
    output logic             busy,
    output logic             any_sat,
    output state_t           state_dbg
);

    // Assertion is asynchronous; release takes effect on the edge after the
    // one that first samples reset high.
    logic rst_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 1'b0;
        end else begin
            rst_sync <= 1'b1;
        end
    end

    logic [NUM_PAT-1:0] flags;
    assign flags = {y111, y110, y101, y100, y011, y010, y001, y000};

    state_t     state, state_n;
    logic [2:0] idx, idx_n;
    logic       xfer;

    assign out_valid = (state == ST_DUMP);
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state <= ST_IDLE;
            idx   <= 3'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        if (clr) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (dump_start) begin
                        state_n = ST_DUMP;
                        idx_n   = 3'd0;
                    end
                end
                ST_DUMP: begin
                    if (xfer) begin
                        // The last entry leaves out_idx at 7 so it keeps
                        // pointing at the final entry while not dumping.
                        if (idx == 3'd7) begin
                            state_n = ST_DONE;
                        end else begin
                            idx_n = idx + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    logic [CNT_W-1:0]   cnt [NUM_PAT];
    logic [NUM_PAT-1:0] sat;

    for (genvar i = 0; i < NUM_PAT; i++) begin : g_cnt
        logic inc_i;
        logic load_i;

        // clr suppresses the hit so the counter lands on exactly 0.
        assign inc_i  = en && flags[i] && !clr;
        assign load_i = clr || (xfer && (idx == 3'(i)));

        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_sync),
            .inc       (inc_i),
            .load_zero (load_i),
            .value     (cnt[i]),
            .sat       (sat[i])
        );
    end

    assign out_idx   = idx;
    assign out_count = cnt[idx];
    assign busy      = (state != ST_IDLE);
    assign any_sat   = |sat;
    assign state_dbg = state;

endmodule : pattern_hit_counter

// File: tb/tb_pattern_hit_counter.sv
// -----------------------------------------------------------------------------
// tb_pattern_hit_counter
// Directed bench for pattern_hit_counter built with CNT_W = 4 so that
// saturation is reachable in a few cycles.
// -----------------------------------------------------------------------------
module tb_pattern_hit_counter;
    import seqdet_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [7:0]   flags;
    logic         clr;
    logic         dump_start;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_idx;
    logic [W-1:0] out_count;
    logic         busy;
    logic         any_sat;
    state_t       state_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    logic [W-1:0] e [8];

    always #5 clk = ~clk;

    pattern_hit_counter #(
        .CNT_W (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .y000       (flags[0]),
        .y001       (flags[1]),
        .y010       (flags[2]),
        .y011       (flags[3]),
        .y100       (flags[4]),
        .y101       (flags[5]),
        .y110       (flags[6]),
        .y111       (flags[7]),
        .clr        (clr),
        .dump_start (dump_start),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_count  (out_count),
        .busy       (busy),
        .any_sat    (any_sat),
        .state_dbg  (state_dbg)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            flags[p] = 1'b1;
            tick();
            flags[p] = 1'b0;
            tick();
        end
    endtask

    task automatic start_dump();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic clear_exp();
        for (int k = 0; k < 8; k++) e[k] = '0;
    endtask

    // Streams all eight entries with out_ready high and compares each one.
    task automatic dump_all(input string name);
        out_ready = 1'b1;
        start_dump();
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_idx !== 3'(k) || out_count !== e[k]) begin
                tests_failed++;
                $display("FAIL %s entry %0d: got valid=%b idx=%0d count=%0d, want valid=1 idx=%0d count=%0d",
                         name, k, out_valid, out_idx, out_count, k, e[k]);
            end
            tick();
        end
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || state_dbg !== ST_DONE) begin
            tests_failed++;
            $display("FAIL %s done: got valid=%b busy=%b state=%0d, want valid=0 busy=1 state=%0d",
                     name, out_valid, busy, state_dbg, ST_DONE);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || state_dbg !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL %s idle: got busy=%b state=%0d, want busy=0 state=%0d",
                     name, busy, state_dbg, ST_IDLE);
        end
    endtask

    // Ticks until the FSM is back in IDLE, with a cycle budget.
    task automatic finish_dump(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 16) begin
            tick();
            n++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, want 0", name, busy, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; en = 1'b0; flags = '0; clr = 1'b0;
        dump_start = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_count !== '0 ||
            busy !== 1'b0 || any_sat !== 1'b0 || state_dbg !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset: got valid=%b idx=%0d count=%0d busy=%b sat=%b state=%0d, want all 0",
                     out_valid, out_idx, out_count, busy, any_sat, state_dbg);
        end
        release_reset();
    endtask

    task automatic test_basic();
        en = 1'b1;
        pulse(5, 3);
        pulse(0, 1);
        clear_exp();
        e[0] = 4'd1;
        e[5] = 4'd3;
        dump_all("basic");
        clear_exp();
        dump_all("basic_reread");
    endtask

    task automatic test_enable();
        en = 1'b0;
        pulse(6, 3);
        en = 1'b1;
        clear_exp();
        dump_all("enable_low");
    endtask

    task automatic test_saturation();
        flags[7] = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        flags[7] = 1'b0;
        tests_run++;
        if (any_sat !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_flag: got any_sat=%b, want 1", any_sat);
        end
        clear_exp();
        e[7] = 4'd15;
        dump_all("saturation");
        tests_run++;
        if (any_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_cleared: got any_sat=%b, want 0", any_sat);
        end
    endtask

    task automatic test_backpressure();
        pulse(2, 2);
        out_ready = 1'b1;
        start_dump();
        tick();
        tick();
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            flags[2] = (s == 2);
            tick();
            flags[2] = 1'b0;
            tests_run++;
            if (out_valid !== 1'b1 || out_idx !== 3'd2 || out_count !== ((s >= 2) ? 4'd3 : 4'd2)) begin
                tests_failed++;
                $display("FAIL stall cycle %0d: got valid=%b idx=%0d count=%0d, want valid=1 idx=2 count=%0d",
                         s, out_valid, out_idx, out_count, (s >= 2) ? 3 : 2);
            end
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_idx !== 3'd3) begin
            tests_failed++;
            $display("FAIL stall_release: got valid=%b idx=%0d, want valid=1 idx=3", out_valid, out_idx);
        end
        finish_dump("backpressure");
        clear_exp();
        dump_all("backpressure_cleared");
    endtask

    task automatic test_rc_hit();
        pulse(3, 4);
        out_ready = 1'b1;
        start_dump();
        tick();
        tick();
        tick();
        tests_run++;
        if (out_idx !== 3'd3 || out_count !== 4'd4) begin
            tests_failed++;
            $display("FAIL rc_read: got idx=%0d count=%0d, want idx=3 count=4", out_idx, out_count);
        end
        flags[3] = 1'b1;
        tick();
        flags[3] = 1'b0;
        finish_dump("rc_hit");
        clear_exp();
        e[3] = 4'd1;
        dump_all("rc_after");
    endtask

    task automatic test_clr();
        pulse(4, 2);
        clr = 1'b1;
        dump_start = 1'b1;
        flags = 8'hFF;
        out_ready = 1'b1;
        tick();
        clr = 1'b0;
        dump_start = 1'b0;
        flags = '0;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL clr: got valid=%b busy=%b state=%0d, want valid=0 busy=0 state=%0d",
                     out_valid, busy, state_dbg, ST_IDLE);
        end
        clear_exp();
        dump_all("clr_zero");
    endtask

    task automatic test_reset_mid_dump();
        pulse(1, 3);
        pulse(4, 2);
        out_ready = 1'b1;
        start_dump();
        for (int k = 0; k < 4; k++) tick();
        tests_run++;
        if (out_idx !== 3'd4 || out_count !== 4'd2) begin
            tests_failed++;
            $display("FAIL pre_reset: got idx=%0d count=%0d, want idx=4 count=2", out_idx, out_count);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_count !== '0 ||
            busy !== 1'b0 || any_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got valid=%b idx=%0d count=%0d busy=%b sat=%b, want all 0",
                     out_valid, out_idx, out_count, busy, any_sat);
        end
        tick();
        tick();
        release_reset();
        pulse(1, 2);
        clear_exp();
        e[1] = 4'd2;
        dump_all("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_enable();
        test_saturation();
        test_backpressure();
        test_rc_hit();
        test_clr();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pattern_hit_counter

// File: doc/pattern_hit_counter.md
PATTERN_HIT_COUNTER -- requirements
Module: pattern_hit_counter

Interface
REQ-001 Parameter CNT_W, default 8, width of each per-pattern hit counter (legal 2..16).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  count enable; hits are ignored when low.
REQ-005 y000..y111  input  1 each  per-pattern detect flags from the upstream sequence detector, sampled each clk.
REQ-006 clr  input  1  synchronous clear of all counters and the dump FSM.
REQ-007 dump_start  input  1  request to stream all 8 counters out.
REQ-008 out_valid  output  1  out_idx/out_count hold a valid entry.
REQ-009 out_ready  input  1  consumer accepts the entry when high with out_valid.
REQ-010 out_idx  output  3  pattern index of the current entry (0 = y000 ... 7 = y111).
REQ-011 out_count  output  CNT_W  counter value for out_idx.
REQ-012 busy  output  1  high while the FSM is not in IDLE.
REQ-013 any_sat  output  1  high while any counter equals 2^CNT_W-1.

Function
REQ-014 Counter i SHALL increment by 1 on each clk edge where en=1 and flag i=1; the flags are independent, so several counters may increment in one cycle.
REQ-015 Each counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-016 FSM states: IDLE, DUMP, DONE.
REQ-017 IDLE -> DUMP on dump_start=1 with out_idx loaded to 0. dump_start in DUMP or DONE SHALL be ignored.
REQ-018 In DUMP, out_valid=1, out_count = live value of counter[out_idx], combinational from the register.
REQ-019 Transfer = out_valid & out_ready. On a transfer, out_idx SHALL advance by 1. On the transfer at index 7, the FSM SHALL go to DONE.
REQ-020 out_valid, out_idx and out_count SHALL be held stable while out_valid=1 and out_ready=0, except that out_count tracks hits on the selected counter.
REQ-021 Read-and-clear: on transfer of index i, counter i SHALL load 0, or 1 if hit i occurs in that same cycle.
REQ-022 DONE SHALL last exactly one cycle with out_valid=0, then return to IDLE. Entry latency is 1 cycle from dump_start to out_valid.
REQ-023 Counting per REQ-014 SHALL continue in every FSM state.
REQ-024 clr=1 SHALL zero all counters and force IDLE, with out_valid=0 next cycle. clr SHALL take priority over hits, dump_start and transfers in the same cycle.
REQ-025 out_valid SHALL be 0 in IDLE and DONE. out_idx SHALL hold its last value outside DUMP.

Reset
REQ-026 While reset=0: all counters 0, FSM IDLE, out_valid 0, out_idx 0, out_count 0, busy 0, any_sat 0.
REQ-027 Assertion of reset mid-dump SHALL abort the dump immediately (asynchronously). Deassertion SHALL be synchronised so that the first active edge is the one after reset is seen high.

Structure
REQ-028 Shared package seqdet_pkg SHALL hold NUM_PAT=8, the default CNT_W, and the FSM state enum.
REQ-029 One sub-module sat_counter (inputs inc, load_zero; parameter CNT_W; output value and sat) SHALL be instantiated 8 times.
REQ-030 Flags SHALL be packed into an 8-bit vector internally, with bit i = pattern i.

Verification
REQ-031 After reset, en=1: pulse y101 three times and y000 once -> dump with out_ready=1 yields entries (0,1),(1,0),...,(5,3),...,(7,0) on 8 consecutive cycles, then DONE, and all counters read 0 on a second dump.
REQ-032 CNT_W=4, y111 held high 20 cycles -> counter 7 = 15, any_sat=1, no wrap.
REQ-033 Dump with out_ready low 5 cycles at index 2 -> out_idx stays 2, out_valid stays 1, no advance until out_ready rises.
REQ-034 y011 high in the cycle index 3 transfers (count 4) -> out_count reads 4, and counter 3 = 1 afterwards.
REQ-035 clr asserted together with dump_start and hits -> next cycle: all counters 0, IDLE, out_valid=0.
REQ-036 reset pulled low at index 4 of a dump -> outputs reach their reset values immediately. After release, en=1 with y001 pulses -> counting resumes from 0.
